// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding
// and the index-counter sizing helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    // 2'd3 is unused; the FSM treats it exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n steps, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle. The master drives operands and accepts
// results; the slave is the adder itself.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    import nibble_serial_adder_pkg::*;

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    modport master (
        output IN_VALID, A, B, CIN, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, OVF
    );

    modport slave (
        input  IN_VALID, A, B, CIN, OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, OVF
    );

endinterface

// File: rtl/nibble_serial_adder_rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice; drop-in compatible
// with the existing 4-bit adder.
module rca4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] SUM,
    output logic       COUT
);

    logic [4:0] c;

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        // NOTE: every output of an always_comb is assigned on every path
        // (here unconditionally) so no latch is inferred; blocking '=' lets
        // each stage see the carry computed by the stage below it.
        c[0] = CIN;
        SUM  = '0;
        for (int i = 0; i < 4; i++) begin
            SUM[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        COUT = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit
// ripple-carry slice, LSB nibble first, with valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 CLK,
    input logic                 RST,
    nibble_serial_adder_if.slave bus
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(N);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   next_partial;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               a_msb;
    logic               b_msb;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic [NIBBLE_W-1:0] slice_sum;
    logic               slice_cout;

    rca4_slice u_slice (
        .A    (op_a[NIBBLE_W-1:0]),
        .B    (op_b[NIBBLE_W-1:0]),
        .CIN  (carry),
        .SUM  (slice_sum),
        .COUT (slice_cout)
    );

    // The new nibble enters at the top so that after N steps the first
    // (LSB) nibble has been pushed down to bit 0.
    assign next_partial = (partial >> NIBBLE_W)
                        | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));

    // Handshake flags decode directly from the registered state.
    assign bus.IN_READY  = (state != RUN) && (state != DONE);
    assign bus.OUT_VALID = (state == DONE);
    assign bus.SUM       = sum_q;
    assign bus.COUT      = cout_q;
    assign bus.OVF       = ovf_q;

    // Single FSM: operand capture, nibble stepping and result load.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values and ordering inside the block is irrelevant.
        if (RST) begin
            // Datapath registers are cleared too so an aborted operation
            // leaves nothing behind and the outputs read back as zero.
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            partial <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    op_a    <= op_a >> NIBBLE_W;
                    op_b    <= op_b >> NIBBLE_W;
                    partial <= next_partial;
                    carry   <= slice_cout;
                    idx     <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N - 1)) begin
                        // Result registers only change here, so they stay
                        // stable through RUN and DONE.
                        state  <= DONE;
                        sum_q  <= next_partial;
                        cout_q <= slice_cout;
                        ovf_q  <= (a_msb == b_msb) && (next_partial[WIDTH-1] != a_msb);
                    end
                end
                DONE: begin
                    if (bus.OUT_READY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    // IDLE, and the unused encoding behaves the same way.
                    state <= IDLE;
                    if (bus.IN_VALID) begin
                        op_a    <= bus.A;
                        op_b    <= bus.B;
                        carry   <= bus.CIN;
                        idx     <= '0;
                        partial <= '0;
                        a_msb   <= bus.A[WIDTH-1];
                        b_msb   <= bus.B[WIDTH-1];
                        state   <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 using a scoreboard
// of expected results filled as operands are driven.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t held;          // result the DUT must keep showing outside DONE loads

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        logic [WIDTH:0] t;
        exp_t r;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Drive operands, record the expected result, wait (bounded) for the
    // accepting edge and leave the bench at the negedge right after it.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin);
        bus.A = a;
        bus.B = b;
        bus.CIN = cin;
        bus.IN_VALID = 1'b1;
        sb.push_back(model(a, b, cin));
        for (int w = 0; w < 20 && !bus.IN_READY; w++) @(negedge clk);
        if (!bus.IN_READY) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.IN_VALID = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    // Compare the DONE outputs against the head of the scoreboard.
    task automatic compare_result();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("done_in_ready", 32'(bus.IN_READY), 32'd0);
        check("sum", 32'(bus.SUM), 32'(e.sum));
        check("cout", 32'(bus.COUT), 32'(e.cout));
        check("ovf", 32'(bus.OVF), 32'(e.ovf));
        held = e;
    endtask

    // Walk through RUN (checking flags and held outputs) until OUT_VALID.
    task automatic finish_op();
        int lat = 0;
        while (!bus.OUT_VALID && lat < 12) begin
            check("run_in_ready", 32'(bus.IN_READY), 32'd0);
            check("run_sum_held", 32'(bus.SUM), 32'(held.sum));
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        if (bus.OUT_VALID) compare_result();
    endtask

    task automatic release_result();
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        bus.OUT_READY = 1'b0;
        check("rel_in_ready", 32'(bus.IN_READY), 32'd1);
        check("rel_out_valid", 32'(bus.OUT_VALID), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
        check({tag, "_sum"}, 32'(bus.SUM), 32'd0);
        check({tag, "_cout"}, 32'(bus.COUT), 32'd0);
        check({tag, "_ovf"}, 32'(bus.OVF), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] b2b_a [3];
        logic [WIDTH-1:0] b2b_b [3];
        logic             b2b_c [3];
        int               acc_t [3];
        int               n_acc;
        int               n_res;
        logic             acc;

        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.CIN = 1'b0;
        held = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        // Basic operations including carry/overflow boundaries.
        start_op(16'h0000, 16'h0000, 1'b0); finish_op(); release_result();
        start_op(16'hFFFF, 16'hFFFF, 1'b1); finish_op(); release_result();
        start_op(16'h7FFF, 16'h0001, 1'b0); finish_op(); release_result();
        start_op(16'h0FFF, 16'h0001, 1'b0); finish_op(); release_result();
        start_op(16'h8000, 16'h8000, 1'b0); finish_op();

        // Backpressure: result held in DONE, new operands ignored.
        bus.A = 16'h1111;
        bus.B = 16'h2222;
        bus.CIN = 1'b0;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.OUT_VALID), 32'd1);
            check("bp_in_ready", 32'(bus.IN_READY), 32'd0);
            check("bp_sum", 32'(bus.SUM), 32'(held.sum));
            check("bp_cout", 32'(bus.COUT), 32'(held.cout));
            check("bp_ovf", 32'(bus.OVF), 32'(held.ovf));
        end
        release_result();
        start_op(16'h1111, 16'h2222, 1'b0); finish_op(); release_result();

        // Mid-operation reset in the second RUN cycle.
        start_op(16'h1234, 16'h1111, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        held = '0;
        start_op(16'h1234, 16'h1111, 1'b1); finish_op(); release_result();

        // Back-to-back with OUT_READY held high: accepts every 6 cycles.
        b2b_a = '{16'h1234, 16'hABCD, 16'hFFFF};
        b2b_b = '{16'h4321, 16'h5432, 16'h0001};
        b2b_c = '{1'b0, 1'b1, 1'b0};
        bus.OUT_READY = 1'b1;
        bus.A = b2b_a[0];
        bus.B = b2b_b[0];
        bus.CIN = b2b_c[0];
        bus.IN_VALID = 1'b1;
        sb.push_back(model(b2b_a[0], b2b_b[0], b2b_c[0]));
        n_acc = 0;
        n_res = 0;
        for (int t = 0; t < 60 && n_res < 3; t++) begin
            if (bus.OUT_VALID) begin
                compare_result();
                n_res++;
            end
            acc = bus.IN_VALID && bus.IN_READY;
            @(posedge clk);
            if (acc && n_acc < 3) begin
                acc_t[n_acc] = t;
                n_acc++;
            end
            @(negedge clk);
            if (acc) begin
                if (n_acc < 3) begin
                    bus.A = b2b_a[n_acc];
                    bus.B = b2b_b[n_acc];
                    bus.CIN = b2b_c[n_acc];
                    sb.push_back(model(b2b_a[n_acc], b2b_b[n_acc], b2b_c[n_acc]));
                end else begin
                    bus.IN_VALID = 1'b0;
                end
            end
        end
        bus.OUT_READY = 1'b0;
        check("b2b_results", n_res, 3);
        check("b2b_accepts", n_acc, 3);
        if (n_acc == 3) begin
            check("b2b_gap1", acc_t[1] - acc_t[0], 6);
            check("b2b_gap2", acc_t[2] - acc_t[1], 6);
        end
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
